alu_share_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that time-shares one combinational ALUexec instance between NREQ requesters, such as the EX stage, branch compare and address generation.
- Accepts one operation at a time, registers the operands, drives the ALU for one cycle, registers the result and returns it with a valid/ready handshake.
- Sits between the execution-stage requesters and the ALU; owns the ALU's input ports exclusively.

---
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer time-sharing one combinational ALU between NREQ requesters
// Optional macro ALU_ARB_LOCK_EN adds req_lock so a requester can keep the grant for back-to-back operations.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*3-1:0]  req_ctrl,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_res,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [2:0]         alu_ctrl,
    input  logic [DW-1:0]      alu_res,
    input  logic               alu_zero
);
    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]      CTRL_ADD = 3'b010;
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [DW-1:0]   res_q, res_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;

    logic [2*NREQ-1:0] rot;
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     grant_next;
    logic              ctrl_legal;
    logic              lock_hold;

`ifdef ALU_ARB_LOCK_EN
    assign lock_hold = req_lock[grant_q];
`else
    assign lock_hold = 1'b0;
`endif

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot   = {req_valid, req_valid} >> ptr_q;
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign grant_next = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;

    always_comb begin
        case (ctrl_q)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: ctrl_legal = 1'b1;
            default:                                ctrl_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        res_d     = res_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = CTRL_ADD;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = ONE << win;
                    grant_d   = win;
                    a_d       = req_a[DW*win +: DW];
                    b_d       = req_b[DW*win +: DW];
                    ctrl_d    = req_ctrl[3*win +: 3];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_ctrl = ctrl_q;
                // Illegal codes never forward ALU output, so no X can escape.
                res_d    = ctrl_legal ? alu_res : '0;
                zero_d   = ctrl_legal & alu_zero;
                err_d    = ~ctrl_legal;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = ONE << grant_q;
                if (rsp_ready[grant_q]) begin
                    ptr_d   = lock_hold ? grant_q : grant_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= CTRL_ADD;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign rsp_res  = res_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*3-1:0]  req_ctrl;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_res;
    logic               rsp_zero;
    logic               rsp_err;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [2:0]         alu_ctrl;
    logic [DW-1:0]      alu_res;
    logic               alu_zero;
`ifdef ALU_ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
    int                 lock_seq [4] = '{0, 1, 1, 0};
`endif

    typedef struct {
        int          r;
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   c0, c1, h;

    alu_share_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Illegal codes return garbage with zero=1 so any leak is visible.
    always_comb begin
        alu_res  = 32'hDEAD_BEEF;
        alu_zero = 1'b1;
        case (alu_ctrl)
            3'b010: alu_res = alu_a + alu_b;
            3'b110: alu_res = alu_a - alu_b;
            3'b000: alu_res = alu_a & alu_b;
            3'b001: alu_res = alu_a | alu_b;
            3'b111: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_res = 32'hDEAD_BEEF;
        endcase
        if (alu_ctrl inside {3'b010, 3'b110, 3'b000, 3'b001, 3'b111})
            alu_zero = (alu_res == 32'b0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [31:0] res, input logic z, input logic e);
        exp_t t;
        t.r = r; t.res = res; t.z = z; t.e = e;
        q.push_back(t);
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req_a[r*DW +: DW] = a;
        req_b[r*DW +: DW] = b;
        req_ctrl[r*3 +: 3] = c;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_accept(input int r, output int at);
        bit got = 1'b0;
        at = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        chk($sformatf("accept_req%0d", r), got, 1);
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (rsp_valid & rsp_ready) != '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_valid", rsp_valid, 64'(2'b01 << mon_e.r));
                chk("rsp_res", rsp_res, mon_e.res);
                chk("rsp_zero", rsp_zero, mon_e.z);
                chk("rsp_err", rsp_err, mon_e.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = {3'b010, 3'b010};
        rsp_ready = 2'b11;
`ifdef ALU_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctrl", alu_ctrl, 3'b010);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op and latency.
        push(0, 32'd8, 1'b0, 1'b0);
        set_req(0, 32'd5, 32'd3, 3'b010);
        wait_accept(0, c0);
        @(negedge clk);
        chk("exec_alu_a", alu_a, 5);
        chk("exec_alu_b", alu_b, 3);
        chk("exec_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("lat_rsp_valid", rsp_valid, 2'b01);
        @(posedge clk);
        #1;

        push(1, 32'd1, 1'b0, 1'b0);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        wait_accept(1, c1);
        repeat (2) @(posedge clk);
        #1;

        // Contention from ptr=0, then a second tie.
        push(0, 32'd0, 1'b1, 1'b0);
        push(1, 32'hFF, 1'b0, 1'b0);
        set_req(0, 32'd7, 32'd7, 3'b110);
        set_req(1, 32'hF0, 32'h0F, 3'b001);
        wait_accept(0, c0);
        wait_accept(1, c1);
        chk("contention_gap", c1 - c0, 3);
        repeat (2) @(posedge clk);
        #1;
        push(0, 32'h30, 1'b0, 1'b0);
        push(1, 32'd0, 1'b1, 1'b0);
        set_req(0, 32'hF0, 32'h3C, 3'b000);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b010);
        wait_accept(0, c0);
        wait_accept(1, c1);
        chk("tie_gap", c1 - c0, 3);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready = 2'b10;
        push(0, 32'd42, 1'b0, 1'b0);
        push(1, 32'd3, 1'b0, 1'b0);
        set_req(0, 32'd100, 32'd58, 3'b110);
        set_req(1, 32'd1, 32'd2, 3'b001);
        wait_accept(0, c0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_rsp_res", rsp_res, 42);
            chk("bp_req_ready1", req_ready[1], 0);
        end
        @(posedge clk);
        #1 rsp_ready = 2'b11;
        @(negedge clk);
        h = cyc;
        chk("bp_hs_req_ready1", req_ready[1], 0);
        wait_accept(1, c1);
        chk("bp_accept_after_hs", c1, h + 1);
        repeat (2) @(posedge clk);
        #1;

        // Illegal control code.
        push(0, 32'd0, 1'b0, 1'b1);
        set_req(0, 32'd1, 32'd2, 3'b011);
        wait_accept(0, c0);
        @(negedge clk);
        @(negedge clk);
        chk("illegal_no_x", $isunknown({req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err,
                                         alu_a, alu_b, alu_ctrl}), 0);
        @(posedge clk);
        #1;

        // Reset while requester 1 is in EXEC; ptr was 1 beforehand.
        set_req(1, 32'd9, 32'd9, 3'b010);
        wait_accept(1, c1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_ctrl", alu_ctrl, 3'b010);
        chk("mid_rst_rsp_err", rsp_err, 0);
        chk("mid_rst_rsp_res", rsp_res, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        push(0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        push(1, 32'd0, 1'b1, 1'b0);
        set_req(0, 32'd3, 32'd5, 3'b110);
        set_req(1, 32'd5, 32'd3, 3'b111);
        wait_accept(0, c0);
        wait_accept(1, c1);
        chk("post_rst_gap", c1 - c0, 3);
        repeat (2) @(posedge clk);
        #1;

`ifdef ALU_ARB_LOCK_EN
        push(0, 32'd2, 1'b0, 1'b0);
        push(1, 32'd4, 1'b0, 1'b0);
        push(1, 32'd4, 1'b0, 1'b0);
        push(0, 32'd2, 1'b0, 1'b0);
        req_lock = 2'b10;
        set_req(0, 32'd1, 32'd1, 3'b010);
        set_req(1, 32'd2, 32'd2, 3'b010);
        for (int n = 0; n < 4; n++) begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (req_ready == '0 && w < 30);
            chk($sformatf("lock_grant%0d", n), req_ready, 64'(2'b01 << lock_seq[n]));
            @(posedge clk);
            #1;
            if (n == 2) req_lock = '0;
            if (n == 3) req_valid = '0;
        end
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
